// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches words into the IF/ID boundary, handles stall/redirect, halts on self-loop, faults out of range
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] InstrAddress,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] InstrOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FetchCount
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] HALT  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, count_q, count_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4, word_idx, jump_target;
    logic        in_range, redirect_ok, fetch, self_loop;

    assign pc_plus4     = pc_q + 32'd4;
    assign word_idx     = {2'b00, pc_q[31:2]};
    assign in_range     = word_idx < MEM_WORDS;
    assign jump_target  = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    assign redirect_ok  = Redirect && state_q != FAULT;
    assign fetch        = state_q == RUN && !Redirect && in_range && !Stall;
    assign self_loop    = fetch && Instruction[31:26] == 6'b000010 && jump_target == pc_q;

    assign InstrAddress = pc_q;
    assign InstrOut     = instr_q;
    assign PCPlus4Out   = pc4_q;
    assign ValidOut     = valid_q;
    assign Halted       = state_q == HALT;
    assign Fault        = state_q == FAULT;
    assign FetchCount   = count_q;

    // Next-state: redirect beats range check, range check beats stall, stall beats fetch
    always_comb begin
        state_d = redirect_ok ? RUN
                : (state_q == RUN && !in_range) ? FAULT
                : self_loop ? HALT
                : state_q;
        pc_d    = redirect_ok ? (RedirectTarget & ~32'h3)
                : (fetch && !self_loop) ? pc_plus4
                : pc_q;
        valid_d = redirect_ok ? 1'b0
                : fetch ? 1'b1
                : (state_q == RUN && in_range && Stall) ? valid_q
                : 1'b0;
        instr_d = fetch ? Instruction : instr_q;
        pc4_d   = fetch ? pc_plus4 : pc4_q;
        count_d = (fetch && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;
    end

    // State registers with synchronous reset that overrides every state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences reads of the combinational 32-bit word instruction memory, which is read with byte address bits [31:2].
- Registers each fetched word, with its PC+4, into the IF/ID boundary using a valid flag.
- Honours stall and redirect requests from later stages.
- Detects the program-end self-loop (`j` to its own address) and stops fetching. Detects fetches beyond the populated memory range and faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- MEM_WORDS, 1024, number of valid instruction words; word indices >= MEM_WORDS fault.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstrAddress  out  32  byte address presented to instruction memory; equals the PC register, combinational from it.
- Instruction  in  32  word returned by instruction memory for InstrAddress, same cycle.
- Stall  in  1  hold PC and IF/ID outputs.
- Redirect  in  1  branch/jump/jr taken; load PC from RedirectTarget.
- RedirectTarget  in  32  new byte address; bits [1:0] are forced to 0.
- InstrOut  out  32  registered fetched instruction.
- PCPlus4Out  out  32  registered address of InstrOut + 4.
- ValidOut  out  1  InstrOut/PCPlus4Out hold a real instruction.
- Halted  out  1  self-loop detected, fetch stopped.
- Fault  out  1  PC left the populated range.
- FetchCount  out  32  number of instructions issued (ValidOut 0->1 or 1->1 loads), saturating.

Behaviour:
- States: RUN, HALT, FAULT.
- Reset values: state RUN, PC = RESET_PC, InstrOut = 0, PCPlus4Out = 0, ValidOut = 0, Halted = 0, Fault = 0, FetchCount = 0.
- Reset takes effect from any state, including mid-stall, HALT or FAULT.
- Per-cycle priority in RUN: Reset > Redirect > range check > Stall > normal fetch.
- Normal fetch (RUN, no stall, no redirect, PC in range):
  - InstrOut <= Instruction; PCPlus4Out <= PC+4; ValidOut <= 1; PC <= PC+4.
  - FetchCount increments, saturating at 32'hFFFF_FFFF.
  - Latency: the instruction at address A appears on InstrOut one cycle after InstrAddress = A.
- Stall (RUN, no redirect): PC, InstrOut, PCPlus4Out, ValidOut and FetchCount all hold.
- Redirect (any state except FAULT):
  - PC <= {RedirectTarget[31:2], 2'b00}; ValidOut <= 0 (bubble); InstrOut and PCPlus4Out hold.
  - State goes to RUN: a redirect out of HALT resumes fetch and clears Halted.
  - Redirect wins over simultaneous Stall.
  - FetchCount does not increment.
- Range check: in RUN with no redirect, if PC[31:2] >= MEM_WORDS, the state goes to FAULT regardless of Stall.
  - In FAULT: Fault = 1, ValidOut <= 0, PC holds.
  - Only Reset exits FAULT; Redirect is ignored.
  - A redirect to an out-of-range target faults on the following cycle.
- Halt detection: on a normal fetch where Instruction[31:26] = 6'b000010 and {PC+4[31:28], Instruction[25:0], 2'b00} == PC:
  - The jump itself is issued normally: ValidOut = 1, FetchCount increments.
  - State goes to HALT and PC holds at the jump address.
- In HALT:
  - Halted = 1; ValidOut <= 0 from the next cycle.
  - PC, InstrOut, PCPlus4Out and FetchCount hold; Stall has no effect.
  - Exit only on Redirect or Reset.
- Non-self-targeting `j`, `jal`, `jr` and branches are not decoded here. They are fetched as ordinary words and rely on Redirect from later stages.
- PC+4 wraps modulo 2^32; in practice the range check faults first.

Test Plan:
- Reset, then run 4 cycles with memory words 0..3 = 20130000, 20140000, 2010ffff, 2011ff00 -> InstrAddress 0,4,8,C. Cycle 1 after reset gives InstrOut = 20130000, PCPlus4Out = 4, ValidOut = 1; FetchCount = 4 after 4 fetches.
- Stall held for 3 cycles at PC = 8 -> InstrAddress stays 8, InstrOut/ValidOut/FetchCount frozen; fetch resumes with 2010ffff on release.
- Redirect with Stall = 1 and RedirectTarget = 32'h0000_01AF -> PC = 0x1AC, ValidOut = 0 next cycle, and the next issued instruction has PCPlus4Out = 0x1B0.
- Word 378 = 0800017a fetched at PC = 0x5E8 -> issued with ValidOut = 1. Next cycle Halted = 1, ValidOut = 0, InstrAddress stays 0x5E8. A later Redirect to 0 clears Halted and restarts fetch from address 0.
- With MEM_WORDS = 16, free-run from 0 -> 16 valid issues, then Fault = 1 with PC = 0x40. A Redirect to 0 is ignored; Reset clears Fault and PC returns to 0.
- Assert Reset during a stall in the middle of a run at PC = 0x20 -> next cycle PC = 0, ValidOut = 0, FetchCount = 0, state RUN.
